mem_sp_hs: RTL and testbench
============================

// Module: mem_sp_hs
// PURPOSE
//   Parametrised synchronous single-port memory with a valid/ready request channel and a
//   buffered valid/ready read-response channel. Replaces the unclocked 64x64 bidirectional-bus
//   memory. Separate write/read data paths, byte enables, configurable read latency and a
//   post-reset clear sweep. Sits between a bus master and the storage array.
// PARAMETERS
//   DATA_W    64   word width in bits; must be a multiple of 8
//   ADDR_W    6    address width; DEPTH = 2**ADDR_W words
//   RD_LAT    1    array read latency in cycles, legal range 1..4
//   INIT_VAL  '0   value written to every word by the post-reset sweep
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         synchronous reset, active low
//   req_valid    in   1         request present
//   req_ready    out  1         request accepted when req_valid & req_ready
//   req_we       in   1         1 = write, 0 = read
//   req_addr     in   ADDR_W    word address
//   req_wdata    in   DATA_W    write data
//   req_be       in   DATA_W/8  byte enables (write only; ignored on read)
//   req_perr_inj in   1         on write, store inverted parity (test hook)
//   rsp_valid    out  1         read data present
//   rsp_ready    in   1         response consumed when rsp_valid & rsp_ready
//   rsp_rdata    out  DATA_W    read data
//   rsp_err      out  1         parity error on this response
//   init_done    out  1         clear sweep complete
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//     init_done=0; response buffer emptied; in-flight reads discarded; state <- INIT, sweep ptr <- 0.
//   - FSM INIT: writes INIT_VAL (good parity) to word ptr each cycle, ptr++. After word DEPTH-1
//     the FSM enters RUN and init_done=1 from the next cycle (DEPTH cycles after reset release).
//     Reset during INIT restarts the sweep from 0. req_ready=0 throughout INIT.
//   - RUN: one operation per cycle (single port). req_ready = (inflight + buffered) < RD_LAT+1.
//   - Write: bytes with req_be[i]=1 are updated at the accept edge; others are kept. No response.
//     A read accepted on any later cycle returns the new data. req_be=0 is a legal no-op.
//   - Read: data enters the response buffer RD_LAT cycles after accept. rsp_valid rises the cycle
//     after that, so minimum accept-to-rsp_valid latency = RD_LAT+1 cycles. Responses are returned
//     in request order. Buffer depth is RD_LAT+1, so back-to-back reads with rsp_ready held high
//     sustain 1 read/cycle. With rsp_ready=0, req_ready drops after RD_LAT+1 outstanding reads.
//   - rsp_valid/rsp_rdata/rsp_err hold stable while rsp_valid & !rsp_ready.
//   - Address wraps naturally; no out-of-range check is possible.
// CONFIGURATION
//   MEM_PARITY_EN defined: one even-parity bit per byte is stored alongside the data.
//     req_perr_inj=1 on a write stores the inverted parity for the enabled bytes.
//     rsp_err=1 when any byte of the read word fails its parity check.
//   MEM_PARITY_EN undefined: no parity storage; req_perr_inj is ignored; rsp_err is tied to 0.
// STRUCTURE
//   mem_pkg: state enum {ST_INIT, ST_RUN}, RD_LAT_MIN/MAX constants, byte-parity function.
//   Sub-module mem_rsp_fifo (sync FIFO, depth RD_LAT+1, data+err) holds read responses.
//   The top level holds the FSM, the storage array, the read-latency shift pipeline and the
//   credit counter.
// TESTING
//   1 rst_n low 2 cycles then high -> init_done=1 exactly 64 cycles later; read of addr 0x3F
//     returns 0.
//   2 Write 0x3A addr=0x05 data=64'h0123456789ABCDEF be=8'hFF, then
//     write data=64'hFFFF_FFFF_FFFF_FFFF be=8'h0F, then read 0x05
//     -> 64'h01234567FFFFFFFF, rsp_valid 2 cycles after accept (RD_LAT=1).
//   3 RD_LAT=3, rsp_ready=0, stream reads -> exactly 4 accepted, then req_ready=0.
//     Raising rsp_ready drains 4 responses in order, then req_ready=1.
//   4 Reads to addr 0..63 back-to-back with rsp_ready=1 -> 64 responses on 64 consecutive
//     cycles, no bubbles.
//   5 rst_n pulsed mid-INIT (cycle 30) and with 2 reads in flight -> no spurious rsp_valid;
//     sweep restarts; init_done after 64 more cycles.
//   6 MEM_PARITY_EN: write addr 0x10 with req_perr_inj=1 be=8'h01, read -> rsp_err=1;
//     rewrite with req_perr_inj=0 -> rsp_err=0. Without the macro rsp_err stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, latency limits and byte-parity helper for mem_sp_hs
package mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Even parity: the stored bit makes the total count of ones in byte+bit even.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_sp_hs_if.sv
// rtl/mem_sp_hs_if.sv - request/response handshake bundle for mem_sp_hs
interface mem_sp_hs_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  req_perr_inj;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, req_perr_inj, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, req_perr_inj, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - small synchronous FIFO buffering read responses (data + error)
module mem_rsp_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  buf_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (count != '0);
    assign do_pop    = pop && out_valid;
    // Output forced to zero when empty so reset leaves rsp_rdata/rsp_err at 0.
    assign out_data  = out_valid ? buf_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mem_sp_hs.sv
// rtl/mem_sp_hs.sv - single-port memory with valid/ready request and buffered read response
// Optional byte parity storage and checking when MEM_PARITY_EN is defined.
module mem_sp_hs
    import mem_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 6,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_sp_hs_if.slave  bus,
    output logic        init_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int CRED  = RD_LAT + 1;
    localparam int CW    = $clog2(CRED + 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     cnt;
    logic              acc, wr, rd, pop, rd_err;
    logic [RD_LAT-1:0] pv;
    logic [DATA_W:0]   pd [RD_LAT];
    logic              f_valid;
    logic [DATA_W:0]   f_data;

    assign acc = bus.req_valid && bus.req_ready;
    assign wr  = acc && bus.req_we;
    assign rd  = acc && !bus.req_we;
    assign pop = f_valid && bus.rsp_ready;

    // A response leaving this cycle frees its credit in time for a new accept.
    assign bus.req_ready = (state == ST_RUN) && ((cnt < CW'(CRED)) || pop);
    assign init_done     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            ST_INIT: begin
                ptr_nx = ptr + ADDR_W'(1);
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nx = ST_RUN;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    function automatic logic [NB-1:0] word_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = byte_par(w[8*i +: 8]);
        end
        return p;
    endfunction

    assign rd_err = |(word_par(mem[bus.req_addr]) ^ par[bus.req_addr]);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                par[ptr] <= word_par(INIT_VAL);
            end else if (wr) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.req_be[i]) begin
                        par[bus.req_addr][i] <= byte_par(bus.req_wdata[8*i +: 8]) ^ bus.req_perr_inj;
                    end
                end
            end
        end
    end
`else
    assign rd_err = bus.req_perr_inj & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[ptr] <= INIT_VAL;
            end else if (wr) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.req_be[i]) begin
                        mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read-latency pipeline; the last stage pushes into the response FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv  <= '0;
            cnt <= '0;
        end else begin
            pv[0] <= rd;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
            end
            cnt <= cnt + CW'(rd) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        pd[0] <= {rd_err, mem[bus.req_addr]};
        for (int i = 1; i < RD_LAT; i++) begin
            pd[i] <= pd[i-1];
        end
    end

    mem_rsp_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (CRED)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pv[RD_LAT-1]),
        .push_data (pd[RD_LAT-1]),
        .pop       (bus.rsp_ready),
        .out_valid (f_valid),
        .out_data  (f_data)
    );

    assign bus.rsp_valid = f_valid;
    assign bus.rsp_err   = f_data[DATA_W];
    assign bus.rsp_rdata = f_data[DATA_W-1:0];
endmodule

// File: tb/tb_mem_sp_hs.sv
// tb/tb_mem_sp_hs.sv - directed self-checking bench for mem_sp_hs (RD_LAT=1 and RD_LAT=3 instances)
module tb_mem_sp_hs;
    logic clk = 1'b0;
    logic rst_n;
    logic done1, done3;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] model [64];
    logic [7:0]  pmodel [64];

`ifdef MEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_sp_hs_if #(.DATA_W(64), .ADDR_W(6)) b1 ();
    mem_sp_hs_if #(.DATA_W(64), .ADDR_W(6)) b3 ();

    mem_sp_hs #(.DATA_W(64), .ADDR_W(6), .RD_LAT(1), .INIT_VAL('0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .init_done(done1));
    mem_sp_hs #(.DATA_W(64), .ADDR_W(6), .RD_LAT(3), .INIT_VAL('0)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .init_done(done3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be, input logic inj);
        int k = 0;
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = a;
        b1.req_wdata = d; b1.req_be = be; b1.req_perr_inj = inj;
        while (!b1.req_ready && k < 50) begin step(); k++; end
        chk("wr_ready_timeout", 64'(k < 50), 64'd1);
        step();
        b1.req_valid = 1'b0; b1.req_perr_inj = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                model[a][8*i +: 8] = d[8*i +: 8];
                pmodel[a][i] = inj;
            end
        end
    endtask

    task automatic rd1(input string tag, input logic [5:0] a, output int lat);
        int k = 0;
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = a;
        while (!b1.req_ready && k < 50) begin step(); k++; end
        step();
        b1.req_valid = 1'b0;
        lat = 1;
        while (!b1.rsp_valid && lat < 50) begin step(); lat++; end
        chk({tag, "_data"}, b1.rsp_rdata, model[a]);
        chk({tag, "_err"}, 64'(b1.rsp_err), 64'(PAR & (|pmodel[a])));
    endtask

    initial begin
        int n, lat, acc, got, cyc, issued, first, last;
        bit fire, spur;
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, acc, got, cyc, issued, first, last;
        bit fire, spur;
        for (int i = 0; i < 64; i++) begin model[i] = '0; pmodel[i] = '0; end
        rst_n = 1'b0;
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = 0; b1.req_wdata = 0;
        b1.req_be = 0; b1.req_perr_inj = 0; b1.rsp_ready = 1;
        b3.req_valid = 0; b3.req_we = 0; b3.req_addr = 0; b3.req_wdata = 0;
        b3.req_be = 0; b3.req_perr_inj = 0; b3.rsp_ready = 1;
        step(); step();

        // Test 1: reset state and init sweep timing
        chk("rst_req_ready", 64'(b1.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(b1.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", b1.rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(b1.rsp_err), 64'd0);
        chk("rst_init_done", 64'(done1), 64'd0);
        rst_n = 1'b1;
        n = 0;
        while (!done1 && n < 200) begin
            chk("init_req_ready", 64'(b1.req_ready), 64'd0);
            step(); n++;
        end
        chk("init_latency", 64'(n), 64'd64);
        chk("init_done3", 64'(done3), 64'd1);
        rd1("t1_rd3f", 6'h3F, lat);

        // Test 2: byte-enable write merge and read latency
        wr1(6'h05, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
        wr1(6'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
        rd1("t2_rd05", 6'h05, lat);
        chk("t2_expect_const", model[5], 64'h01234567FFFFFFFF);
        chk("t2_latency", 64'(lat), 64'd2);
        wr1(6'h05, 64'h0, 8'h00, 1'b0);
        rd1("t2_be0", 6'h05, lat);

        // Test 6: parity injection then clean rewrite
        wr1(6'h10, 64'h0000_0000_0000_00A5, 8'h01, 1'b1);
        rd1("t6_inj", 6'h10, lat);
        chk("t6_err_set", 64'(b1.rsp_err), 64'(PAR));
        wr1(6'h10, 64'h0000_0000_0000_00A5, 8'h01, 1'b0);
        rd1("t6_clean", 6'h10, lat);
        chk("t6_err_clr", 64'(b1.rsp_err), 64'd0);
        step();

        // Test 4: 64 back-to-back reads, responses on consecutive cycles
        wr1(6'h3F, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0);
        wr1(6'h00, 64'h1122_3344_5566_7788, 8'hF0, 1'b0);
        issued = 0; got = 0; cyc = 0; first = -1; last = -1;
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 6'd0;
        while (got < 64 && cyc < 300) begin
            fire = b1.req_valid && b1.req_ready;
            if (b1.rsp_valid) begin
                chk("t4_data", b1.rsp_rdata, model[got]);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            step(); cyc++;
            if (fire) begin
                issued++;
                if (issued == 64) b1.req_valid = 1'b0;
                else b1.req_addr = 6'(issued);
            end
        end
        chk("t4_count", 64'(got), 64'd64);
        chk("t4_no_bubble", 64'(last - first), 64'd63);

        // Test 3: RD_LAT=3 credit limit with stalled response channel
        for (int i = 0; i < 4; i++) begin
            b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_addr = 6'(i);
            b3.req_wdata = 64'h1000 + 64'(i); b3.req_be = 8'hFF;
            chk("t3_wr_ready", 64'(b3.req_ready), 64'd1);
            step();
        end
        b3.req_we = 1'b0; b3.req_addr = 6'd0; b3.rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            fire = b3.req_valid && b3.req_ready;
            step();
            if (fire) begin acc++; b3.req_addr = 6'(acc); end
        end
        chk("t3_accepted", 64'(acc), 64'd4);
        chk("t3_ready_low", 64'(b3.req_ready), 64'd0);
        chk("t3_hold_valid", 64'(b3.rsp_valid), 64'd1);
        chk("t3_hold_data", b3.rsp_rdata, 64'h1000);
        b3.req_valid = 1'b0; b3.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (b3.rsp_valid) begin
                chk("t3_order", b3.rsp_rdata, 64'h1000 + 64'(got));
                got++;
            end
            step();
        end
        chk("t3_drained", 64'(got), 64'd4);
        chk("t3_ready_back", 64'(b3.req_ready), 64'd1);

        // Test 5: reset with reads in flight, then reset mid-sweep
        b3.req_valid = 1'b1; b3.req_addr = 6'd1;
        step(); step();
        b3.req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        spur = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (b3.rsp_valid || b1.rsp_valid) spur = 1'b1;
            step();
        end
        chk("t5_mid_init_done", 64'(done1), 64'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        while (!done3 && n < 200) begin
            if (b3.rsp_valid || b1.rsp_valid) spur = 1'b1;
            step(); n++;
        end
        chk("t5_no_spurious", 64'(spur), 64'd0);
        chk("t5_init_latency", 64'(n), 64'd64);
        for (int i = 0; i < 64; i++) begin model[i] = '0; pmodel[i] = '0; end
        rd1("t5_cleared", 6'h05, lat);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
